// File: rtl/pri_codec_pkg.sv
// pri_codec_pkg: definitions shared by the priority encoder and decoder.
//   state_e       - decoder FSM states (ST_GAP is used only when the design
//                   is built with PRI_DEC_GAP_EN).
//   DEF_N_OUT     - default number of one-hot lines. The encoder uses the same
//                   value, so both ends agree on the code width.
//   DEF_PULSE_LEN - default number of cycles a decoded line stays asserted.
package pri_codec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_N_OUT     = 4;
  localparam int DEF_PULSE_LEN = 4;

endpackage

// File: rtl/pri_decoder_seq_if.sv
// pri_decoder_seq_if: code handshake and strobe outputs of the priority decoder.
//   master - upstream side: drives enable, in_valid and in_code; observes
//            in_ready, D_out, busy and done.
//   slave  - decoder side (the mirror image of master).
// Parameters: N_OUT = number of one-hot lines; W = code width (derived, do not override).
interface pri_decoder_seq_if #(
  parameter int N_OUT = pri_codec_pkg::DEF_N_OUT,
  parameter int W     = $clog2(N_OUT)
);
  logic             enable;
  logic             in_valid;
  logic [W-1:0]     in_code;
  logic             in_ready;
  logic [N_OUT-1:0] D_out;
  logic             busy;
  logic             done;

  modport master (
    output enable, in_valid, in_code,
    input  in_ready, D_out, busy, done
  );

  modport slave (
    input  enable, in_valid, in_code,
    output in_ready, D_out, busy, done
  );
endinterface

// File: rtl/pri_decoder_seq_onehot_dec.sv
// onehot_dec: combinational binary-to-one-hot decoder.
//   code_i   [W-1:0]     - binary line index
//   onehot_o [N_OUT-1:0] - the matching one-hot line; all zero when
//                          code_i >= N_OUT
module onehot_dec #(
  parameter int N_OUT = 4,
  parameter int W     = $clog2(N_OUT)
) (
  input  logic [W-1:0]     code_i,
  output logic [N_OUT-1:0] onehot_o
);
  // The per-line compare yields zero for out-of-range codes without a
  // separate range check.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot_o[i] = (code_i == W'(i));
    end
  end
endmodule

// File: rtl/pri_decoder_seq.sv
// pri_decoder_seq: sequential priority-code decoder.
// The block accepts a code over a valid/ready handshake. It drives the
// matching one-hot line for PULSE_LEN cycles, then releases the line and
// pulses done for one cycle.
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst_n - asynchronous, active-low reset
//   bus   - pri_decoder_seq_if.slave:
//             enable, in_valid, in_code (inputs)
//             in_ready, D_out, busy, done (outputs)
// Build option: define PRI_DEC_GAP_EN to add a one-cycle GAP state after each
// normal completion, which gives break-before-make on downstream select lines.
module pri_decoder_seq
  import pri_codec_pkg::*;
#(
  parameter int N_OUT     = DEF_N_OUT,
  parameter int W         = $clog2(N_OUT),
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input logic              clk,
  input logic              rst_n,
  pri_decoder_seq_if.slave bus
);
  localparam int CW = $clog2(PULSE_LEN + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [N_OUT-1:0] dout_q;
  logic             done_q;
  logic [N_OUT-1:0] onehot;

  onehot_dec #(.N_OUT(N_OUT), .W(W)) u_dec (
    .code_i   (bus.in_code),
    .onehot_o (onehot)
  );

  // in_ready is gated by rst_n so that it reads 0 while reset is asserted.
  assign bus.in_ready = rst_n && bus.enable && (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.D_out    = dout_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Dropping enable aborts silently. It takes priority over counter
      // expiry, so an aborted pulse never produces done.
      if (!bus.enable) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        dout_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.in_valid) begin
              dout_q  <= onehot;
              cnt_q   <= CW'(PULSE_LEN - 1);
              state_q <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            if (cnt_q == '0) begin
              dout_q <= '0;
              done_q <= 1'b1;
`ifdef PRI_DEC_GAP_EN
              state_q <= ST_GAP;
`else
              state_q <= ST_IDLE;
`endif
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
`ifdef PRI_DEC_GAP_EN
          ST_GAP:  state_q <= ST_IDLE;
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pri_decoder_seq.sv
// Bench for pri_decoder_seq (N_OUT=4, PULSE_LEN=4).
// A reference model pushes the expected outputs for each clock edge into a
// queue. A monitor pops that queue on the falling edge and compares.
module tb_pri_decoder_seq;
  localparam int N_OUT     = 4;
  localparam int W         = 2;
  localparam int PULSE_LEN = 4;
`ifdef PRI_DEC_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  typedef struct {
    logic [N_OUT-1:0] dout;
    logic             done;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  pri_decoder_seq_if #(.N_OUT(N_OUT)) bus();

  pri_decoder_seq #(.N_OUT(N_OUT), .PULSE_LEN(PULSE_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model. It tracks the number of cycles left in the current
  // pulse, the line being driven, and whether a gap cycle is pending.
  int               m_rem;
  logic [N_OUT-1:0] m_line;
  bit               m_gap;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_rem = 0; m_line = '0; m_gap = 0;
      exp_q.delete();
    end else begin
      e.done = 1'b0;
      if (!bus.enable) begin
        m_rem = 0; m_gap = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          e.done = 1'b1;
          m_gap  = GAP;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (bus.in_valid) begin
        m_rem  = PULSE_LEN;
        m_line = (int'(bus.in_code) < N_OUT) ? N_OUT'(1) << bus.in_code : '0;
      end
      e.dout = (m_rem > 0) ? m_line : '0;
      e.busy = (m_rem > 0) || m_gap;
      exp_q.push_back(e);
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (!rst_n) begin
      n_checks++;
      if (bus.D_out !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got D_out=%b done=%b busy=%b in_ready=%b, want all 0",
                 bus.D_out, bus.done, bus.busy, bus.in_ready);
      end
    end else if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty at %0t: got D_out=%b, want a queued expectation", $time, bus.D_out);
    end else begin
      e = exp_q.pop_front();
      exp_rdy = !e.busy && bus.enable;
      n_checks++;
      if (bus.D_out !== e.dout || bus.done !== e.done || bus.busy !== e.busy || bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL cycle_out at %0t: got D_out=%b done=%b busy=%b rdy=%b, want D_out=%b done=%b busy=%b rdy=%b",
                 $time, bus.D_out, bus.done, bus.busy, bus.in_ready, e.dout, e.done, e.busy, exp_rdy);
      end
    end
  end

  // Drive inputs 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a code and hold it until it is accepted (bounded wait).
  task automatic send(input int code);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = W'(code);
    forever begin
      @(negedge clk);
      #1;
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, want 1", n);
        break;
      end
    end
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    // Reset with valid and enable high.
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.in_valid = 1'b1; bus.in_code = 2'd1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick(2);

    // Single code 2.
    send(2);
    tick(8);

    // Back-to-back codes 3 then 0.
    send(3);
    send(0);
    tick(8);

    // Drop enable on the 2nd cycle of a code-1 pulse.
    send(1);
    bus.enable = 1'b0;
    tick(2);
    bus.enable = 1'b1;
    send(2);
    tick(7);

    // Enable low in IDLE: a presented code is ignored.
    bus.enable = 1'b0; bus.in_valid = 1'b1; bus.in_code = 2'd3;
    tick(3);
    bus.enable = 1'b1;
    send(3);
    tick(7);

    // Code held valid while busy and changing from 1 to 3.
    send(1);
    bus.in_valid = 1'b1; bus.in_code = 2'd3;
    tick(1);
    send(3);
    tick(7);

    // Asynchronous reset on cycle 2 of a pulse.
    send(1);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.D_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got D_out=%b, want 0000", bus.D_out);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick(1);
    send(0);
    tick(7);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_code  = W'($urandom_range(0, N_OUT - 1));
      bus.enable   = ($urandom_range(0, 15) != 0);
      tick(1);
    end
    bus.enable = 1'b1; bus.in_valid = 1'b0;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pri_decoder_seq.md
# pri_decoder_seq

Sequential 2-to-4 priority-code decoder, the receiving end of the 4-input priority encoder path. It accepts a binary code through a valid/ready handshake and drives the matching one-hot output line for a programmable number of cycles. It then releases the line, pulses `done` and waits for the next code. It sits downstream of the encoder: the encoder produces the code, and this block turns it back into a timed select/strobe line.

## Interface
Parameters:
- `N_OUT`, default 4: number of one-hot output lines; ≥2.
- `W`, default `$clog2(N_OUT)`: code width. Derived; do not override.
- `PULSE_LEN`, default 4: cycles each output line stays asserted; ≥1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `enable`, in, 1: block enable; low forces idle and aborts any active pulse.
- `in_valid`, in, 1: code present on `in_code`.
- `in_code`, in, W: binary index of the line to drive.
- `in_ready`, out, 1: block can accept a code this cycle.
- `D_out`, out, N_OUT: registered one-hot output; all zero when idle.
- `busy`, out, 1: high while in DRIVE (and GAP when compiled in).
- `done`, out, 1: one-cycle pulse when a pulse completes normally.

## Operation
- FSM states:
  - IDLE: `in_ready = enable`.
  - DRIVE: `D_out` asserted; `in_ready = 0`.
  - GAP: only with `PRI_DEC_GAP_EN`.
- Accept happens when `in_valid && in_ready` at a rising edge. On that edge:
  - `D_out <= 1 << in_code`.
  - The down-counter loads `PULSE_LEN-1`.
  - The state moves to DRIVE.
- In DRIVE, the counter decrements each cycle. When the counter is 0 at an edge:
  - `D_out <= 0`.
  - `done <= 1` for one cycle.
  - The state moves to IDLE, or to GAP when the macro is defined.
- Counter width is `$clog2(PULSE_LEN+1)`. It never wraps, because it is only loaded on accept and stops at 0.
- `in_code >= N_OUT` (possible only when N_OUT is not a power of 2): the code is accepted and timed normally, `D_out` stays all zero, and `done` still pulses.
- `enable` low in IDLE: `in_ready = 0`; `in_valid` is ignored.
- `enable` low at an edge while in DRIVE or GAP: abort.
  - `D_out <= 0`, the counter clears, and the state moves to IDLE.
  - No `done`.
- `enable` low takes priority over counter expiry on the same edge, so there is no `done`.
- `in_valid` with `in_ready` low: nothing is latched. The upstream side holds the code.
- Reset values: `D_out = 0`, `done = 0`, `busy = 0`, `in_ready = 0` (state IDLE; `in_ready` follows `enable` combinationally once out of reset). Counter = 0.
- Reset asserted mid-pulse clears all outputs immediately (asynchronously). After release the block starts in IDLE.

## Timing
- Accept at edge k: `D_out` is one-hot from edge k to edge k+PULSE_LEN, which is exactly PULSE_LEN cycles.
- `done` is high from edge k+PULSE_LEN for one cycle. `in_ready` returns high in that same cycle (without GAP).
- Back-to-back codes: the next accept is earliest at edge k+PULSE_LEN+1. That leaves one all-zero cycle between pulses without GAP, and two with GAP.
- `in_ready` and `busy` are combinational from state and `enable`. `D_out` and `done` are registered.
- Latency from accept to output is 0 cycles after the accepting edge.

## Configuration
- `PRI_DEC_GAP_EN` defined:
  - After normal completion, the FSM spends exactly one cycle in GAP with `in_ready = 0`, `busy = 1` and `D_out = 0`, then moves to IDLE.
  - This guarantees break-before-make on downstream select lines.
- `PRI_DEC_GAP_EN` not defined: the GAP state does not exist, and the FSM moves from DRIVE directly to IDLE.

## Structure
- Shared package `pri_codec_pkg` holds:
  - The FSM state enum (`ST_IDLE`, `ST_DRIVE`, `ST_GAP`).
  - The default `N_OUT`/`PULSE_LEN` constants, so the encoder and decoder agree on the code width.
- One natural sub-module, `onehot_dec`, is purely combinational: `W`-bit code → `N_OUT`-bit one-hot, with zero output for out-of-range codes. The top module holds the FSM, counter and output registers.

## Test plan
- Reset with `rst_n=0` while `in_valid=1` and `enable=1`: `D_out=0`, `done=0`, `busy=0`. After release, `in_ready=1`.
- `enable=1`, PULSE_LEN=4, send code 2: `D_out=4'b0100` for exactly 4 cycles, then `4'b0000`; `done` high for 1 cycle on the falling edge of `D_out`.
- Codes 3 then 0 held valid back-to-back: `D_out=4'b1000` for 4 cycles, then 1 zero cycle (2 with `PRI_DEC_GAP_EN`), then `4'b0001` for 4 cycles; two `done` pulses.
- Drop `enable` on the 2nd cycle of a code-1 pulse: `D_out` goes to `0` on that edge, no `done`, and the next code is accepted once `enable=1`.
- `in_valid=1` while busy, with `in_code` changing from 1 to 3: the latched line stays bit 1, and code 3 is accepted only after `done`.
- Async reset mid-pulse (cycle 2 of 4): `D_out` goes to `0` without a clock edge. After release, code 0 gives a full 4-cycle pulse.
